mem_responder: RTL and testbench

- Memory-side responder for the CPU's read/write request bus.
- Serves operand and opcode reads from the instruction fetcher, and load/store accesses from the execute path.
- Decodes the 16-bit address into three regions: mirrored internal RAM, a wait-stated read-only program window, and unmapped open bus.
- Every accepted request gets exactly one ack pulse, with fixed per-region latency.

---
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: mirrored RAM, wait-stated program window and open-bus
// decode behind a req/ack handshake with one ack pulse per accepted request.
module mem_responder #(
    parameter int REG_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int RAM_DEPTH   = 2048,
    parameter int ROM_DEPTH   = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]  wdata,
    output logic                  ack,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  err,
    output logic                  busy,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [REG_WIDTH-1:0]  prog_data
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int ROM_AW = $clog2(ROM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {RGN_RAM, RGN_ROM, RGN_OPEN} rgn_t;

    logic [REG_WIDTH-1:0] ram_mem [RAM_DEPTH];
    logic [REG_WIDTH-1:0] rom_mem [ROM_DEPTH];

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [ROM_AW-1:0]    rom_idx_q, rom_idx_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;

    logic                 ram_we;
    rgn_t                 rgn;
    logic [RAM_AW-1:0]    ram_idx;
    logic [ROM_AW-1:0]    rom_rd_idx;
    logic [ROM_AW-1:0]    prog_idx;
    logic [REG_WIDTH-1:0] rom_val;
    logic                 unused_addr_bits;

    assign ram_idx          = addr[RAM_AW-1:0];
    assign prog_idx         = prog_addr[ROM_AW-1:0];
    assign unused_addr_bits = ^{addr, prog_addr};

    always_comb begin
        rgn = RGN_OPEN;
        if (addr[ADDR_WIDTH-1]) begin
            rgn = RGN_ROM;
        end else if (addr[ADDR_WIDTH-2:ADDR_WIDTH-3] == 2'b00) begin
            rgn = RGN_RAM;
        end
    end

    // A load landing on the same edge as the read's ack edge must be visible.
    always_comb begin
        rom_rd_idx = (state_q == IDLE) ? addr[ROM_AW-1:0] : rom_idx_q;
        rom_val    = (prog_we && (prog_idx == rom_rd_idx)) ? prog_data : rom_mem[rom_rd_idx];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rom_idx_d = rom_idx_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        busy_d    = 1'b0;
        rdata_d   = rdata_q;
        ram_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    rom_idx_d = addr[ROM_AW-1:0];
                    busy_d    = 1'b1;
                    state_d   = RESP;
                    ack_d     = 1'b1;
                    case (rgn)
                        RGN_RAM: begin
                            if (we) begin
                                ram_we = 1'b1;
                            end else begin
                                rdata_d = ram_mem[ram_idx];
                            end
                        end
                        RGN_ROM: begin
                            if (we) begin
                                err_d = 1'b1;
                            end else if (WAIT_STATES == 0) begin
                                rdata_d = rom_val;
                            end else begin
                                state_d = WAIT;
                                ack_d   = 1'b0;
                                cnt_d   = 3'(WAIT_STATES - 1);
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    rdata_d = rom_val;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            rom_idx_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rom_idx_q <= rom_idx_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
        end
    end

    // RAM writes commit on the edge that raises ack, so reset on that edge cancels them.
    always_ff @(posedge phi1) begin
        if (!reset && ram_we) begin
            ram_mem[ram_idx] <= wdata;
        end
        if (!reset && prog_we) begin
            rom_mem[prog_idx] <= prog_data;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM mirror, program window, open bus,
// back-to-back, reset abort and wait-state variants.
module tb_mem_responder;

    logic        phi1 = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        prog_we = 1'b0;
    logic [15:0] prog_addr = 16'h0000;
    logic [7:0]  prog_data = 8'h00;

    logic       ack, err, busy;
    logic [7:0] rdata;
    logic       ack0, err0, busy0;
    logic [7:0] rdata0;
    logic       ack7, err7, busy7;
    logic [7:0] rdata7;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 phi1 = ~phi1;

    mem_responder #(.WAIT_STATES(2)) dut (
        .phi1(phi1), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    mem_responder #(.WAIT_STATES(0)) dut_ws0 (
        .phi1(phi1), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    mem_responder #(.WAIT_STATES(7)) dut_ws7 (
        .phi1(phi1), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack7), .rdata(rdata7), .err(err7), .busy(busy7),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic prog_load(input logic [15:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    // Leaves any ack cycle, issues one request, returns ack latency (-1 on timeout).
    task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic er);
        step();
        req = 1'b1; we = w; addr = a; wdata = d;
        step();
        req = 1'b0;
        lat = 1;
        while (!ack && lat < 20) begin
            step();
            lat++;
        end
        if (!ack) lat = -1;
        rd = rdata;
        er = err;
    endtask

    initial begin
        int         lat;
        logic [7:0] rd;
        logic       er;
        logic [3:0] ack_seq, busy_seq;
        int         ack_cnt, first0, first2, first7;
        logic [7:0] rd0;

        step();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        reset = 1'b0;

        // RAM and mirrors
        txn(1'b1, 16'h0012, 8'hA5, lat, rd, er);
        check("ram_wr_lat", 32'(lat), 32'd1);
        check("ram_wr_err", 32'(er), 32'h0);
        txn(1'b0, 16'h0812, 8'h00, lat, rd, er);
        check("ram_rd_lat", 32'(lat), 32'd1);
        check("ram_rd_0812", 32'(rd), 32'hA5);
        check("ram_rd_err", 32'(er), 32'h0);
        txn(1'b0, 16'h1812, 8'h00, lat, rd, er);
        check("ram_rd_1812", 32'(rd), 32'hA5);

        // Program window
        prog_load(16'h0003, 8'hEA);
        txn(1'b0, 16'h8003, 8'h00, lat, rd, er);
        check("rom_rd_lat", 32'(lat), 32'd3);
        check("rom_rd_8003", 32'(rd), 32'hEA);
        check("rom_rd_err", 32'(er), 32'h0);
        txn(1'b0, 16'h9003, 8'h00, lat, rd, er);
        check("rom_rd_9003", 32'(rd), 32'hEA);
        txn(1'b1, 16'h8003, 8'h00, lat, rd, er);
        check("rom_wr_lat", 32'(lat), 32'd1);
        check("rom_wr_err", 32'(er), 32'h1);
        check("rom_wr_rdata_hold", 32'(rd), 32'hEA);
        txn(1'b0, 16'h8003, 8'h00, lat, rd, er);
        check("rom_rd_after_wr", 32'(rd), 32'hEA);

        // Load landing on the ack edge is visible to the read
        prog_load(16'h0005, 8'h00);
        req = 1'b1; we = 1'b0; addr = 16'h8005;
        step();
        req = 1'b0;
        step();
        prog_we = 1'b1; prog_addr = 16'h0005; prog_data = 8'h3C;
        step();
        prog_we = 1'b0;
        check("rom_fwd_ack", 32'(ack), 32'h1);
        check("rom_fwd_rdata", 32'(rdata), 32'h3C);

        // Open bus
        txn(1'b1, 16'h0100, 8'h5C, lat, rd, er);
        txn(1'b0, 16'h0100, 8'h00, lat, rd, er);
        check("ram_rd_5c", 32'(rd), 32'h5C);
        txn(1'b0, 16'h4000, 8'h00, lat, rd, er);
        check("open_rd_lat", 32'(lat), 32'd1);
        check("open_rd_err", 32'(er), 32'h1);
        check("open_rd_rdata", 32'(rd), 32'h5C);
        txn(1'b1, 16'h0000, 8'h77, lat, rd, er);
        txn(1'b1, 16'h2000, 8'h11, lat, rd, er);
        check("open_wr_err", 32'(er), 32'h1);
        txn(1'b0, 16'h0000, 8'h00, lat, rd, er);
        check("open_wr_no_ram", 32'(rd), 32'h77);
        check("ram_err_clear", 32'(er), 32'h0);

        // Back-to-back with req held
        step();
        req = 1'b1; we = 1'b0; addr = 16'h0012;
        step();
        for (int i = 0; i < 4; i++) begin
            ack_seq[i]  = ack;
            busy_seq[i] = busy;
            if (i == 2) req = 1'b0;
            step();
        end
        check("b2b_ack_seq", 32'(ack_seq), 32'h5);
        check("b2b_busy_seq", 32'(busy_seq), 32'h5);

        // Reset during WAIT of a program read
        step();
        req = 1'b1; we = 1'b0; addr = 16'h8000;
        step();
        req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_ack", 32'(ack), 32'h0);
        check("rst_wait_busy", 32'(busy), 32'h0);
        check("rst_wait_rdata", 32'(rdata), 32'h0);
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack) ack_cnt++;
            step();
        end
        check("rst_wait_no_ack", 32'(ack_cnt), 32'h0);

        // RAM write aborted by reset on its ack edge
        req = 1'b1; we = 1'b1; addr = 16'h0012; wdata = 8'hFF; reset = 1'b1;
        step();
        req = 1'b0; we = 1'b0; reset = 1'b0;
        check("rst_wr_no_ack", 32'(ack), 32'h0);
        txn(1'b0, 16'h0012, 8'h00, lat, rd, er);
        check("rst_wr_old_byte", 32'(rd), 32'hA5);

        // Wait-state variants, all instances from a common reset
        do_reset();
        req = 1'b1; we = 1'b0; addr = 16'h8003;
        step();
        req = 1'b0;
        first0 = -1; first2 = -1; first7 = -1; rd0 = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            if (ack0 && first0 < 0) begin first0 = k; rd0 = rdata0; end
            if (ack && first2 < 0) first2 = k;
            if (ack7 && first7 < 0) first7 = k;
            step();
        end
        check("ws0_lat", 32'(first0), 32'd1);
        check("ws0_rdata", 32'(rd0), 32'hEA);
        check("ws2_lat", 32'(first2), 32'd3);
        check("ws7_lat", 32'(first7), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
